// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   state_e      : glue FSM states (IDLE, CONV, LATCH)
//   MINUS_CODE   : digit code the cathode decoder renders as '-'
//   NBCD         : BCD digits kept for a 16-bit magnitude
//   SIGN_SLOT    : fixed sign position when leading-zero blanking is off
//   bcd_digits_t : packed BCD digit vector, index 0 = units
//   msd_index    : position of the most significant non-zero digit (0 for zero)
package disp_pkg;

   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_e;

   localparam logic [3:0]  MINUS_CODE = 4'b1010;
   localparam int unsigned NBCD       = 5;
   localparam int unsigned SIGN_SLOT  = 5;

   typedef logic [NBCD-1:0][3:0] bcd_digits_t;

   function automatic int unsigned msd_index(input bcd_digits_t d);
      int unsigned m;
      m = 0;
      for (int unsigned i = 0; i < NBCD; i++) begin
         if (d[i] != 4'd0) m = i;
      end
      return m;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
// A start_i pulse while idle loads mag_i and clears the BCD accumulator; the
// following W cycles each perform one add-3/shift step.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : load request, ignored while busy_o
//   mag_i      : unsigned magnitude to convert
//   busy_o     : conversion in progress
//   done_o     : high during the cycle whose closing edge performs the last shift
//   bcd_o      : BCD accumulator, final once busy_o drops
module bin2bcd_seq
   import disp_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [W-1:0] mag_i,
   output logic         busy_o,
   output logic         done_o,
   output bcd_digits_t  bcd_o
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LastBit = CW'(W - 1);

   bcd_digits_t                bcd_q, bcd_d, adj;
   logic [W-1:0]               mag_q, mag_d;
   logic [CW-1:0]              cnt_q;
   logic                       busy_q;
   logic [4*NBCD+W-1:0]        shifted;

   always_comb begin
      for (int unsigned i = 0; i < NBCD; i++) begin
         adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
      end
      shifted        = {adj, mag_q} << 1;
      {bcd_d, mag_d} = shifted;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q  <= '0;
         mag_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (!busy_q) begin
         if (start_i) begin
            bcd_q  <= '0;
            mag_q  <= mag_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end
      end else begin
         bcd_q <= bcd_d;
         mag_q <= mag_d;
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == LastBit) busy_q <= 1'b0;
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == LastBit);
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Seven-segment scan controller for the Booth multiplier product.
// Converts a signed product to sign + 5 BCD digits, latches them, and
// time-multiplexes them onto NDIG active-low anodes (slot 0 = rightmost).
//   clk, rst_n : clock, asynchronous active-low reset
//   valid      : load strobe, accepted only in IDLE
//   producto   : signed product
//   digito     : digit code for the cathode decoder (0-9, 4'b1010 = minus)
//   anodo      : active-low anode enables, registered together with digito
//   busy       : conversion (CONV or LATCH) in progress
//   done       : one-cycle pulse when new digits reach the display registers
// Build option LEADING_ZERO_BLANK_EN: blank leading zeros and float the minus
// sign to just left of the most significant shown digit.
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned W           = 16,
   parameter int unsigned NDIG        = 8,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid,
   input  logic [W-1:0]    producto,
   output logic [3:0]      digito,
   output logic [NDIG-1:0] anodo,
   output logic            busy,
   output logic            done
);

   localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RW-1:0] RefLast = RW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IdxLast = IW'(NDIG - 1);

   // ---------------- conversion FSM ----------------
   state_e       state_q, state_d;
   logic         start, latch_en, eng_busy, eng_done;
   logic [W-1:0] mag_in;
   logic         sign_conv_q;
   bcd_digits_t  eng_bcd;

   assign start  = (state_q == IDLE) && valid;
   // -32768 negates to itself, which read unsigned is the wanted 32768.
   assign mag_in = producto[W-1] ? (~producto + W'(1)) : producto;

   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      unique case (state_q)
         IDLE:    if (valid) state_d = CONV;
         CONV:    if (eng_done) state_d = LATCH;
         LATCH: begin
            latch_en = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   bin2bcd_seq #(
      .W (W)
   ) u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .mag_i   (mag_in),
      .busy_o  (eng_busy),
      .done_o  (eng_done),
      .bcd_o   (eng_bcd)
   );

   // ---------------- display registers ----------------
   bcd_digits_t     disp_bcd_q;
   logic            disp_neg_q;
   logic            done_q;
   logic [NBCD-1:0] show_mask;
   logic [IW-1:0]   sign_pos;

`ifdef LEADING_ZERO_BLANK_EN
   logic [NBCD-1:0] show_q, show_d;
   logic [IW-1:0]   sign_pos_q, sign_pos_d;

   always_comb begin
      int unsigned msd;
      msd        = msd_index(eng_bcd);
      show_d     = '0;
      for (int unsigned i = 0; i < NBCD; i++) begin
         if (i <= msd) show_d[i] = 1'b1;
      end
      sign_pos_d = IW'(msd + 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         show_q     <= NBCD'(1);
         sign_pos_q <= IW'(1);
      end else if (latch_en) begin
         show_q     <= show_d;
         sign_pos_q <= sign_pos_d;
      end
   end

   assign show_mask = show_q;
   assign sign_pos  = sign_pos_q;
`else
   assign show_mask = '1;
   assign sign_pos  = IW'(SIGN_SLOT);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sign_conv_q <= 1'b0;
         disp_bcd_q  <= '0;
         disp_neg_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= latch_en;
         if (start) sign_conv_q <= producto[W-1];
         if (latch_en) begin
            disp_bcd_q <= eng_bcd;
            disp_neg_q <= sign_conv_q;
         end
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

   // ---------------- scan ----------------
   logic [RW-1:0]   ref_q;
   logic [IW-1:0]   idx_q;
   logic [NDIG-1:0] anodo_q, anodo_d;
   logic [3:0]      digito_q, digito_d;
   logic [3:0]      slot_dig;
   logic            slot_show;

   always_comb begin
      slot_dig  = 4'd0;
      slot_show = 1'b0;
      for (int unsigned i = 0; i < NBCD; i++) begin
         if (idx_q == IW'(i)) begin
            slot_dig  = disp_bcd_q[i];
            slot_show = show_mask[i];
         end
      end
      anodo_d  = '1;
      digito_d = 4'd0;
      if (disp_neg_q && (idx_q == sign_pos)) begin
         anodo_d  = ~(NDIG'(1) << idx_q);
         digito_d = MINUS_CODE;
      end else if (slot_show) begin
         anodo_d  = ~(NDIG'(1) << idx_q);
         digito_d = slot_dig;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_q    <= '0;
         idx_q    <= '0;
         anodo_q  <= '1;
         digito_q <= 4'd0;
      end else begin
         anodo_q  <= anodo_d;
         digito_q <= digito_d;
         if (ref_q == RefLast) begin
            ref_q <= '0;
            idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
         end else begin
            ref_q <= ref_q + 1'b1;
         end
      end
   end

   assign anodo  = anodo_q;
   assign digito = digito_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with REFRESH_DIV=4: directed and random loads,
// handshake timing, ignored strobes, mid-conversion reset and full scan frames
// compared against an arithmetic model of the display.
module tb_display_scan_ctrl;

   localparam int W    = 16;
   localparam int NDIG = 8;
   localparam int RD   = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            valid = 1'b0;
   logic [W-1:0]    producto = '0;
   logic [3:0]      digito;
   logic [NDIG-1:0] anodo;
   logic            busy;
   logic            done;

   int n_checks = 0;
   int n_err    = 0;
   int tcyc     = 0;
   int model_mag = 0;
   bit model_neg = 1'b0;

   display_scan_ctrl #(
      .W           (W),
      .NDIG        (NDIG),
      .REFRESH_DIV (RD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (valid),
      .producto (producto),
      .digito   (digito),
      .anodo    (anodo),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Rising edges since the last reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tcyc <= 0;
      else        tcyc <= tcyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int ndigits(input int m);
      int n;
      n = 1;
      while (m >= 10) begin
         m = m / 10;
         n++;
      end
      return n;
   endfunction

   // Expected {anodo, digito} after rising edge t of the scan.
   function automatic logic [11:0] exp_out(input int t, input int mag, input bit neg);
      int slot, p, dig;
      logic [7:0] lit;
      if (t == 0) return {8'hFF, 4'h0};
      slot = ((t - 1) / RD) % NDIG;
      p = 1;
      for (int i = 0; i < slot; i++) p = p * 10;
      dig = (mag / p) % 10;
      lit = 8'hFF & ~(8'd1 << slot);
`ifdef LEADING_ZERO_BLANK_EN
      if (slot < ndigits(mag))             return {lit, 4'(dig)};
      if (neg && slot == ndigits(mag))     return {lit, 4'hA};
      return {8'hFF, 4'h0};
`else
      if (slot < 5)                        return {lit, 4'(dig)};
      if (neg && slot == 5)                return {lit, 4'hA};
      return {8'hFF, 4'h0};
`endif
   endfunction

   task automatic check_frame(input string tag);
      logic [11:0] e;
      repeat (NDIG * RD) begin
         @(negedge clk);
         e = exp_out(tcyc, model_mag, model_neg);
         chk({tag, " anodo"}, 32'(anodo), 32'(e[11:4]));
         chk({tag, " digito"}, 32'(digito), 32'(e[3:0]));
      end
   endtask

   // Load v; optionally strobe sv five cycles in and strobe again in LATCH.
   task automatic load(input logic [W-1:0] v, input bit stray, input logic [W-1:0] sv);
      @(negedge clk);
      producto = v;
      valid    = 1'b1;
      @(negedge clk);
      valid    = 1'b0;
      producto = W'($urandom);
      for (int j = 0; j <= 16; j++) begin
         chk("busy during conversion", 32'(busy), 32'd1);
         chk("done during conversion", 32'(done), 32'd0);
         valid = stray && (j == 5 || j == 16);
         if (stray && j == 5) producto = sv;
         @(negedge clk);
      end
      valid = 1'b0;
      chk("busy after latch", 32'(busy), 32'd0);
      chk("done pulse", 32'(done), 32'd1);
      model_neg = v[W-1];
      model_mag = v[W-1] ? 65536 - int'(v) : int'(v);
      repeat (3) begin
         @(negedge clk);
         chk("busy idle", 32'(busy), 32'd0);
         chk("done single", 32'(done), 32'd0);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset anodo", 32'(anodo), 32'hFF);
      chk("reset digito", 32'(digito), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      rst_n = 1'b1;
      check_frame("zero after reset");

      load(16'd1234, 1'b0, '0);
      check_frame("1234");
      load(-16'sd305, 1'b0, '0);
      check_frame("-305");
      load(16'h8000, 1'b0, '0);
      check_frame("-32768");
      load(16'd0, 1'b0, '0);
      check_frame("zero");
      load(16'd777, 1'b1, 16'd4321);
      check_frame("ignored strobe");

      for (int k = 0; k < 6; k++) begin
         load(W'($urandom), 1'b0, '0);
         check_frame("random");
      end

      // Reset eight cycles into a conversion.
      load(16'd9999, 1'b0, '0);
      @(negedge clk);
      producto = 16'd4242;
      valid    = 1'b1;
      @(negedge clk);
      valid    = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midconv reset anodo", 32'(anodo), 32'hFF);
      chk("midconv reset digito", 32'(digito), 32'd0);
      chk("midconv reset busy", 32'(busy), 32'd0);
      chk("midconv reset done", 32'(done), 32'd0);
      model_mag = 0;
      model_neg = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) begin
         @(negedge clk);
         chk("no done after abort", 32'(done), 32'd0);
         chk("no busy after abort", 32'(busy), 32'd0);
      end
      check_frame("zero after abort");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
